// File: rtl/output_queue_if.sv
// rtl/output_queue_if.sv - sample stream in, DAC strobe/status out for output_queue
// Optional OUTPUT_QUEUE_UNDERRUN_COUNT_EN adds the underrun_count signal.
interface output_queue_if #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 64
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_last;
   logic              s_ready;
   logic [DATA_W-1:0] dac_data;
   logic              dac_strobe;
   logic [LW-1:0]     level;
   logic              running;
   logic              underrun;
`ifdef OUTPUT_QUEUE_UNDERRUN_COUNT_EN
   logic [15:0]       underrun_count;

   modport slave (
      input  s_data, s_valid, s_last,
      output s_ready, dac_data, dac_strobe, level, running, underrun, underrun_count
   );

   modport master (
      output s_data, s_valid, s_last,
      input  s_ready, dac_data, dac_strobe, level, running, underrun, underrun_count
   );
`else
   modport slave (
      input  s_data, s_valid, s_last,
      output s_ready, dac_data, dac_strobe, level, running, underrun
   );

   modport master (
      output s_data, s_valid, s_last,
      input  s_ready, dac_data, dac_strobe, level, running, underrun
   );
`endif
endinterface

// File: rtl/output_queue.sv
// rtl/output_queue.sv - FIFO-buffered, fixed-rate sample playback to a DAC
// Optional saturating underrun counter: OUTPUT_QUEUE_UNDERRUN_COUNT_EN.
module output_queue #(
   parameter int DATA_W  = 12,
   parameter int DEPTH   = 64,
   parameter int RATE    = 2267,
   parameter int PREFILL = 32
) (
   input  logic           clk,
   input  logic           reset_n,
   output_queue_if.slave  q
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(RATE);

   localparam logic [LW-1:0]     FULL_LVL    = LW'(DEPTH);
   localparam logic [LW-1:0]     PREFILL_LVL = LW'(PREFILL);
   localparam logic [CW-1:0]     CNT_MAX     = CW'(RATE - 1);
   localparam logic [DATA_W-1:0] MIDSCALE    = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q, state_d;
   logic [DATA_W:0]   mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [LW-1:0]     last_cnt_q, last_cnt_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] dac_data_q, dac_data_d;
   logic              strobe_q, strobe_d;
   logic              under_q, under_d;

   logic              push;
   logic              pop;
   logic              tick;
   logic              empty;
   logic [DATA_W:0]   head;

   assign q.s_ready = (level_q != FULL_LVL);
   assign empty     = (level_q == '0);
   assign push      = q.s_valid && q.s_ready;
   assign head      = mem_q[rd_ptr_q];
   assign tick      = (state_q == RUN) && (cnt_q == CNT_MAX);
   assign pop       = tick && !empty;

   // Storage is never reset: pointers and level alone define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {q.s_last, q.s_data};
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      last_cnt_d = last_cnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
      // Tracks how many queued entries close a stream, so IDLE can start early.
      case ({push && q.s_last, pop && head[DATA_W]})
         2'b10:   last_cnt_d = last_cnt_q + 1'b1;
         2'b01:   last_cnt_d = last_cnt_q - 1'b1;
         default: last_cnt_d = last_cnt_q;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dac_data_d = dac_data_q;
      strobe_d   = 1'b0;
      under_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if ((level_q >= PREFILL_LVL) || (last_cnt_q != '0)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
               strobe_d = 1'b1;
               // Empty tick: DAC re-sends the held sample and underrun is flagged.
               if (empty) begin
                  under_d = 1'b1;
               end else begin
                  dac_data_d = head[DATA_W-1:0];
                  if (head[DATA_W]) begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         last_cnt_q <= '0;
         cnt_q      <= '0;
         dac_data_q <= MIDSCALE;
         strobe_q   <= 1'b0;
         under_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         last_cnt_q <= last_cnt_d;
         cnt_q      <= cnt_d;
         dac_data_q <= dac_data_d;
         strobe_q   <= strobe_d;
         under_q    <= under_d;
      end
   end

   assign q.dac_data   = dac_data_q;
   assign q.dac_strobe = strobe_q;
   assign q.level      = level_q;
   assign q.running    = (state_q == RUN);
   assign q.underrun   = under_q;

`ifdef OUTPUT_QUEUE_UNDERRUN_COUNT_EN
   logic [15:0] ucnt_q, ucnt_d;

   // Counts on the same edge that raises underrun, so both are visible together.
   always_comb begin
      ucnt_d = ucnt_q;
      if (under_d && (ucnt_q != 16'hFFFF)) begin
         ucnt_d = ucnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ucnt_q <= '0;
      end else begin
         ucnt_q <= ucnt_d;
      end
   end

   assign q.underrun_count = ucnt_q;
`endif
endmodule

// File: doc/output_queue.md
Name: output_queue

Overview:
- Playback-side counterpart to the sampled-ADC input path.
- Accepts processed audio samples from the pitch-shift datapath over a valid/ready stream and buffers them in a FIFO.
- Emits exactly one sample to the DAC every RATE clocks (2267 clocks at 100 MHz ≈ 44.1 kHz).
- Absorbs bursty producer output and reports underrun when the producer falls behind.

Parameters:
DATA_W, 12, sample width (matches ADC sample width)
DEPTH, 64, FIFO entries; power of 2, ≥ 2
RATE, 2267, clock cycles per output sample; ≥ 2
PREFILL, 32, FIFO level required before playback starts; 1 ≤ PREFILL ≤ DEPTH

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
s_data  in  DATA_W  input sample
s_valid  in  1  s_data valid
s_last  in  1  marks final sample of a stream; qualified by s_valid
s_ready  out  1  queue can accept a beat
dac_data  out  DATA_W  sample presented to DAC; held between strobes
dac_strobe  out  1  one-cycle pulse, dac_data updated this cycle
level  out  $clog2(DEPTH)+1  current FIFO occupancy
running  out  1  1 while in RUN state
underrun  out  1  one-cycle pulse, tick occurred with FIFO empty
underrun_count  out  16  saturating underrun count (only with macro)

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: dac_data=1<<(DATA_W-1) (midscale), dac_strobe=0, level=0, running=0, underrun=0, underrun_count=0.
  - Pointers cleared; FIFO contents discarded.
  - Applies immediately, including mid-run.
- FIFO storage:
  - Each entry is DATA_W+1 bits: {last, data}.
  - Write/read pointers wrap modulo DEPTH.
  - level is a registered occupancy count.
- Push:
  - s_ready = (level != DEPTH), combinational from the level register; equals 1 out of reset.
  - A beat is accepted on an edge where s_valid && s_ready.
- States:
  - IDLE:
    - Rate counter held at 0; no pops, no strobes.
    - -> RUN on the edge after a cycle in which level ≥ PREFILL, or in which the FIFO holds an entry with last=1.
  - RUN:
    - Counter counts 0..RATE-1 and wraps; a tick is the cycle where counter == RATE-1.
    - On the tick edge, FIFO non-empty: pop head; dac_data ← head.data; dac_strobe=1 next cycle.
    - If the popped entry has last=1: -> IDLE on the same edge. dac_data holds that value; no underrun is reported.
    - On the tick edge, FIFO empty: dac_strobe=1 and underrun=1 next cycle; dac_data unchanged (DAC re-sends held sample); remain in RUN.
- Latency:
  - First dac_strobe is high in the cycle RATE cycles after the first RUN cycle.
  - Subsequent strobes occur exactly every RATE cycles, with no jitter.
- Simultaneous push and pop: level unchanged; both operations take effect.
- Full with pop: s_ready stays 0 in the tick cycle and returns to 1 the cycle after.
- Push of a beat into an empty FIFO on a tick edge: not visible to that tick; underrun is reported.

Optional Feature:
Macro OUTPUT_QUEUE_UNDERRUN_COUNT_EN.
- Defined:
  - underrun_count port exists.
  - Increments on every underrun pulse and saturates at 0xFFFF.
  - Cleared only by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
Bench configuration: DATA_W=12, DEPTH=8, RATE=10, PREFILL=4.
1. Reset: assert reset_n=0 mid-cycle -> immediately dac_data=0x800, dac_strobe=0, level=0, running=0, s_ready=1.
2. Prefill/order: push 0x001..0x004 back-to-back -> running=1 the cycle after level=4. Strobes at 10-cycle spacing carry 0x001, 0x002, 0x003, 0x004; level decrements once per strobe.
3. Full: push 10 beats 0x010..0x019 back-to-back from empty with s_valid held -> s_ready drops when level=8. Only 8 beats accepted before the first pop; the next beat is accepted the cycle after the first strobe.
4. Underrun: after scenario 2 drains -> next tick gives dac_strobe=1, underrun=1 for one cycle, dac_data=0x004, running stays 1. With macro defined, underrun_count=1, then 2 after the next tick.
5. Last: from IDLE, push 0x0A0, then 0x0A1 with s_last=1 -> RUN starts below PREFILL. Emits 0x0A0 then 0x0A1, returns to IDLE, no underrun, no further strobes.
6. Reset mid-run: assert reset_n=0 with level=5 between strobes -> all outputs at reset values, level=0. After release, pushing 4 new samples replays only the new samples.
